// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: built-in self-test sequencer for a small combinational gate.
// Drives every input pattern in turn and holds each one for SETTLE cycles.
// It then samples the gate output once and compares it with the TRUTH table.
// At the end of a sweep it reports the mismatch count, the first failing
// vector and a pass flag, along with a one-cycle done pulse.
//
// Handshake: start is a level request that is only looked at in IDLE. It is
// never queued, so a start seen while busy or in DONE is dropped. Holding
// start high re-arms on the IDLE cycle that follows DONE.
module gate_sweep_ctrl #(
    parameter int                      N_IN   = 4,
    parameter int                      SETTLE = 1,
    parameter logic [(1<<N_IN)-1:0]    TRUTH  = 16'h8000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [N_IN-1:0] vec,
    input  logic            dut_o,
    output logic            busy,
    output logic            done,
    output logic            pass,
    output logic [N_IN:0]   err_cnt,
    output logic [N_IN-1:0] first_fail,
    output logic            first_fail_vld
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_DRIVE  = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    // The settle counter only has to reach SETTLE-1.
    localparam int             CW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CW-1:0]  SETTLE_LAST = CW'(SETTLE - 1);
    localparam logic [N_IN-1:0] VEC_LAST   = '1;

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [CW-1:0] settle_cnt;
    logic          mismatch;

    // The gate output disagrees with the expected table entry for this vector.
    assign mismatch = (dut_o != TRUTH[vec]);

    assign busy = (state == S_DRIVE) || (state == S_SAMPLE);
    assign done = (state == S_DONE);

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (start) state_nxt = S_DRIVE;
            S_DRIVE:  if (settle_cnt == SETTLE_LAST) state_nxt = S_SAMPLE;
            S_SAMPLE: state_nxt = (vec == VEC_LAST) ? S_DONE : S_DRIVE;
            S_DONE:   state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // State register, vector stepping, settle timing and result accumulation.
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= S_IDLE;
            vec            <= '0;
            settle_cnt     <= '0;
            err_cnt        <= '0;
            first_fail     <= '0;
            first_fail_vld <= 1'b0;
            pass           <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                S_IDLE: begin
                    vec <= '0;
                    if (start) begin
                        settle_cnt     <= '0;
                        err_cnt        <= '0;
                        first_fail     <= '0;
                        first_fail_vld <= 1'b0;
                        pass           <= 1'b0;
                    end
                end
                S_DRIVE: begin
                    settle_cnt <= settle_cnt + 1'b1;
                end
                S_SAMPLE: begin
                    if (mismatch) begin
                        err_cnt <= err_cnt + 1'b1;
                        if (!first_fail_vld) begin
                            first_fail     <= vec;
                            first_fail_vld <= 1'b1;
                        end
                    end
                    if (vec == VEC_LAST) begin
                        // Registered here so that pass is already valid in
                        // DONE and still counts the final vector's result.
                        pass <= (err_cnt == '0) && !mismatch;
                    end else begin
                        vec        <= vec + 1'b1;
                        settle_cnt <= '0;
                    end
                end
                S_DONE: begin
                    vec <= '0;
                end
                default: begin
                    vec <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// Directed bench for gate_sweep_ctrl. Instance u_a uses the default AND4
// table and drives a gate model that can be switched between correct,
// stuck-at-0 and stuck-at-1. Instance u_b uses SETTLE=3 with an OR4 table
// and drives a correct OR4 model.
module tb_gate_sweep_ctrl;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    logic start_a, start_b;
    int   mode;   // 0 correct, 1 stuck-at-0, 2 stuck-at-1
    int   sel;    // which instance the run task observes

    logic [3:0] vec_a, vec_b, first_fail_a, first_fail_b;
    logic [4:0] err_cnt_a, err_cnt_b;
    logic       dut_o_a, dut_o_b, busy_a, busy_b, done_a, done_b;
    logic       pass_a, pass_b, ffv_a, ffv_b;

    assign dut_o_a = (mode == 0) ? (&vec_a) : (mode == 1) ? 1'b0 : 1'b1;
    assign dut_o_b = |vec_b;

    gate_sweep_ctrl u_a (
        .clk(clk), .rst(rst), .start(start_a), .vec(vec_a), .dut_o(dut_o_a),
        .busy(busy_a), .done(done_a), .pass(pass_a), .err_cnt(err_cnt_a),
        .first_fail(first_fail_a), .first_fail_vld(ffv_a)
    );

    gate_sweep_ctrl #(.N_IN(4), .SETTLE(3), .TRUTH(16'hFFFE)) u_b (
        .clk(clk), .rst(rst), .start(start_b), .vec(vec_b), .dut_o(dut_o_b),
        .busy(busy_b), .done(done_b), .pass(pass_b), .err_cnt(err_cnt_b),
        .first_fail(first_fail_b), .first_fail_vld(ffv_b)
    );

    logic [3:0] cur_vec, cur_ff;
    logic [4:0] cur_err;
    logic       cur_busy, cur_done, cur_pass, cur_ffv;
    assign cur_vec  = (sel == 0) ? vec_a        : vec_b;
    assign cur_ff   = (sel == 0) ? first_fail_a : first_fail_b;
    assign cur_err  = (sel == 0) ? err_cnt_a    : err_cnt_b;
    assign cur_busy = (sel == 0) ? busy_a       : busy_b;
    assign cur_done = (sel == 0) ? done_a       : done_b;
    assign cur_pass = (sel == 0) ? pass_a       : pass_b;
    assign cur_ffv  = (sel == 0) ? ffv_a        : ffv_b;

    // ---------------- checking ----------------
    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full sweep on instance sel. Cycle 1 is the first cycle after the
    // edge that accepted start. Stray start pulses are injected while busy.
    task automatic run_sweep(input int s, input string tag, input int settle,
                             input int exp_done, input int exp_err, input int exp_ff,
                             input int exp_ffv, input int exp_pass);
        int c;
        int seq_err;
        int got_done;
        sel = s;
        if (s == 0) start_a = 1'b1; else start_b = 1'b1;
        tick;
        start_a = 1'b0;
        start_b = 1'b0;
        c        = 1;
        seq_err  = 0;
        got_done = 0;
        while (c <= 200 && got_done == 0) begin
            if (cur_done) begin
                got_done = c;
            end else begin
                if (int'(cur_vec) != (c - 1) / (settle + 1) || !cur_busy) seq_err++;
                if (s == 0) start_a = (c % 7 == 3); else start_b = (c % 7 == 3);
                tick;
                c++;
            end
        end
        start_a = 1'b0;
        start_b = 1'b0;
        check({tag, "_done_cycle"}, got_done, exp_done);
        check({tag, "_vec_seq"}, seq_err, 0);
        check({tag, "_busy_in_done"}, cur_busy, 0);
        check({tag, "_err_cnt"}, cur_err, exp_err);
        check({tag, "_ffv"}, cur_ffv, exp_ffv);
        if (exp_ffv != 0) check({tag, "_first_fail"}, cur_ff, exp_ff);
        check({tag, "_pass"}, cur_pass, exp_pass);
        tick;
        check({tag, "_done_pulse_1cyc"}, cur_done, 0);
        check({tag, "_pass_held"}, cur_pass, exp_pass);
        check({tag, "_err_held"}, cur_err, exp_err);
        check({tag, "_vec_idle"}, cur_vec, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int done_n, low_n, d1, d2, found;
        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        mode    = 0;
        sel     = 0;
        tick;
        tick;
        check("rst_vec",   vec_a,     0);
        check("rst_busy",  busy_a,    0);
        check("rst_done",  done_a,    0);
        check("rst_pass",  pass_a,    0);
        check("rst_err",   err_cnt_a, 0);
        check("rst_ffv",   ffv_a,     0);
        check("rst_b_busy", busy_b,   0);
        rst = 1'b0;
        tick;

        // Correct AND4: 33-cycle sweep, clean result.
        mode = 0;
        run_sweep(0, "and_ok", 1, 33, 0, 0, 0, 1);
        // Stuck-at-0: only vector F mismatches.
        mode = 1;
        run_sweep(0, "stuck0", 1, 33, 1, 15, 1, 0);
        // Stuck-at-1: vectors 0..E mismatch.
        mode = 2;
        run_sweep(0, "stuck1", 1, 33, 15, 0, 1, 0);

        // start held high for 80 cycles: back-to-back runs.
        mode    = 0;
        sel     = 0;
        start_a = 1'b1;
        tick;
        done_n = 0; low_n = 0; d1 = 0; d2 = 0;
        for (int c = 1; c <= 80; c++) begin
            if (done_a) begin
                done_n++;
                if (d1 == 0) d1 = c; else if (d2 == 0) d2 = c;
            end
            if (!busy_a) low_n++;
            tick;
        end
        start_a = 1'b0;
        check("held_done_count", done_n, 2);
        check("held_done1_cycle", d1, 33);
        check("held_done2_cycle", d2, 67);
        check("held_busy_low", low_n, 4);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        tick;

        // Reset mid-run at vec==7 with a failing gate.
        mode    = 2;
        start_a = 1'b1;
        tick;
        start_a = 1'b0;
        found = 0;
        for (int c = 0; c < 100 && found == 0; c++) begin
            if (vec_a == 4'd7) found = 1; else tick;
        end
        check("mid_reach_vec7", found, 1);
        check("mid_err_before", err_cnt_a, 7);
        rst = 1'b1;
        tick;
        rst = 1'b0;
        check("mid_rst_vec",  vec_a,     0);
        check("mid_rst_busy", busy_a,    0);
        check("mid_rst_err",  err_cnt_a, 0);
        check("mid_rst_pass", pass_a,    0);
        check("mid_rst_ffv",  ffv_a,     0);
        check("mid_rst_done", done_a,    0);
        done_n = 0; low_n = 0;
        for (int c = 0; c < 40; c++) begin
            if (done_a) done_n++;
            if (busy_a) low_n++;
            tick;
        end
        check("mid_no_done", done_n, 0);
        check("mid_stays_idle", low_n, 0);
        mode = 0;
        run_sweep(0, "after_rst", 1, 33, 0, 0, 0, 1);

        // SETTLE=3, OR4 table, correct OR4 gate: 4 cycles per vector.
        run_sweep(1, "or4", 3, 65, 0, 0, 0, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
